control_fifo_muestras: RTL and testbench
========================================

# control_fifo_muestras

Sample-buffer controller for the filter datapath, sitting directly upstream of the occupancy up/down counter (`sumador_restador`, instantiated with `BITS_VALOR = BITS_DIRECCION+1`). It stores incoming samples in a circular buffer with valid/ready handshakes on both sides. Every cycle it issues the `actualizar`/`operacion` pair that drives the counter, and reads the counter's `valor_actual` back as `ocupacion` to derive full and empty. It also cross-checks that count against its own pointers and latches any mismatch.

## Interface
- `BITS_DATOS`, 8, sample width.
- `BITS_DIRECCION`, 3, address width; depth `PROFUNDIDAD = 2^BITS_DIRECCION`.

- `clk` input 1: single clock; everything is registered on the rising edge.
- `reset` input 1: synchronous, active-high; shared with the counter.
- `escribir_valido` input 1: producer offers `datos_entrada`.
- `datos_entrada` input BITS_DATOS: sample to store.
- `escribir_listo` output 1: buffer can accept a sample.
- `leer_valido` output 1: `datos_salida` holds the oldest sample.
- `datos_salida` output BITS_DATOS: oldest stored sample (first-word fall-through).
- `leer_listo` input 1: consumer takes the sample.
- `ocupacion` input BITS_DIRECCION+1: counter `valor_actual`.
- `actualizar` output 1: counter enable.
- `operacion` output 1: counter direction (1 = increment, 0 = decrement).
- `error_ocupacion` output 1: sticky flag for count/pointer mismatch.

## Operation
- Pointers: `ptr_escritura` and `ptr_lectura` are each BITS_DIRECCION+1 bits wide. The low BITS_DIRECCION bits address memory. Pointers increment modulo 2^(BITS_DIRECCION+1), so the address wraps modulo PROFUNDIDAD.
- Full/empty flags (combinational from `ocupacion`):
  - `lleno` = (`ocupacion` == PROFUNDIDAD).
  - `vacio` = (`ocupacion` == 0).
  - `escribir_listo` = !`lleno` && !`reset`.
  - `leer_valido` = !`vacio` && !`reset`.
- Transfers:
  - Write transfer: `w` = `escribir_valido` && `escribir_listo`. On the edge, `mem[ptr_escritura]` ← `datos_entrada` and `ptr_escritura` increments.
  - Read transfer: `r` = `leer_valido` && `leer_listo`. On the edge, `ptr_lectura` increments.
- `datos_salida` = `mem[ptr_lectura[BITS_DIRECCION-1:0]]`, read asynchronously. It is a don't-care while `leer_valido` = 0.
- Counter command (combinational):
  - `w` only: `actualizar` = 1, `operacion` = 1.
  - `r` only: `actualizar` = 1, `operacion` = 0.
  - Both or neither: `actualizar` = 0, `operacion` = 0.
- Simultaneous read and write:
  - Both transfers complete and occupancy is unchanged.
  - When full, a write is refused even if a read happens in the same cycle; there is no full bypass.
  - When empty, a write does not bypass to the output.
- Consistency check: each cycle, compare `ocupacion` with (`ptr_escritura` − `ptr_lectura`) mod 2^(BITS_DIRECCION+1). Any inequality sets `error_ocupacion` on that edge. It stays set until reset.
- Out-of-range `ocupacion` (> PROFUNDIDAD): `lleno` and `vacio` are both 0, so both handshakes stay enabled, and the mismatch sets `error_ocupacion`. The flag is the only required response.
- Reset:
  - Pointers → 0, `error_ocupacion` → 0. Memory contents are not cleared.
  - While `reset` = 1: `actualizar` = 0, `operacion` = 0, `escribir_listo` = 0, `leer_valido` = 0.
  - Reset mid-stream drops all stored samples. The counter resets on the same edge, so the state stays consistent.

## Timing
- Counter contract: the counter updates on the same edge that the controller's pointers move. `ocupacion` therefore reflects all transfers up to the previous edge.
- Write-to-read latency: a sample written at edge k is visible with `leer_valido` = 1 in the cycle after edge k. `datos_salida` equals that sample.
- Full: after PROFUNDIDAD write-only edges, `escribir_listo` drops in the next cycle. After one read it rises again in the following cycle.
- Throughput: one write and one read per cycle sustained while 0 < `ocupacion` < PROFUNDIDAD.
- Error latency: `error_ocupacion` rises one edge after the first mismatching cycle.
- All outputs except registered `error_ocupacion` are combinational from state and inputs. There are no combinational paths from `leer_listo` to `escribir_listo` or the reverse.

## Test plan
Parameters `BITS_DATOS` = 8, `BITS_DIRECCION` = 3; counter instantiated alongside.
1. Reset, then write 0x11 → `actualizar` = 1, `operacion` = 1 that cycle. Next cycle: `leer_valido` = 1, `datos_salida` = 0x11, `ocupacion` = 1.
2. Write 0x01–0x08 back-to-back with `leer_listo` = 0 → `escribir_listo` = 0 once `ocupacion` = 8. A 9th offer (0x09) is not stored. Reading all 8 returns 0x01–0x08 in order, then `leer_valido` = 0.
3. At `ocupacion` = 4, assert write and read together for 20 cycles → `actualizar` = 0 throughout, `ocupacion` stays 4, output order preserved. Pointers wrap past address 7 with no data loss.
4. Full (8 entries) with `escribir_valido` = 1 and `leer_listo` = 1 in the same cycle → read only, `operacion` = 0, `ocupacion` = 7. The write is accepted next cycle.
5. Store 5 samples, assert `reset` for 1 cycle → `ocupacion` = 0, `leer_valido` = 0, `error_ocupacion` = 0. A new write of 0xAA reads back 0xAA.
6. Force `ocupacion` = 2 while pointers differ by 3 → `error_ocupacion` = 1 after one edge, stays 1 after the mismatch is removed, and clears only on `reset`.

Source files
------------

// File: rtl/control_fifo_muestras.sv
// Sample buffer controller: circular buffer with valid/ready on both sides,
// drives the external occupancy counter and cross-checks it against its pointers.
module control_fifo_muestras #(
    parameter int BITS_DATOS     = 8,
    parameter int BITS_DIRECCION = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      escribir_valido,
    input  logic [BITS_DATOS-1:0]     datos_entrada,
    output logic                      escribir_listo,
    output logic                      leer_valido,
    output logic [BITS_DATOS-1:0]     datos_salida,
    input  logic                      leer_listo,
    input  logic [BITS_DIRECCION:0]   ocupacion,
    output logic                      actualizar,
    output logic                      operacion,
    output logic                      error_ocupacion
);

    localparam int PROFUNDIDAD = 1 << BITS_DIRECCION;
    localparam logic [BITS_DIRECCION:0] OCUPACION_LLENO = PROFUNDIDAD[BITS_DIRECCION:0];
    localparam logic [BITS_DIRECCION:0] PASO = {{BITS_DIRECCION{1'b0}}, 1'b1};

    logic [BITS_DATOS-1:0]   mem [PROFUNDIDAD];
    logic [BITS_DIRECCION:0] ptr_escritura;
    logic [BITS_DIRECCION:0] ptr_lectura;
    logic [BITS_DIRECCION:0] diferencia;
    logic                    lleno;
    logic                    vacio;
    logic                    w;
    logic                    r;

    // Full/empty come from the external counter, not from the pointers.
    assign lleno          = (ocupacion == OCUPACION_LLENO);
    assign vacio          = (ocupacion == '0);
    assign escribir_listo = !lleno && !reset;
    assign leer_valido    = !vacio && !reset;

    assign w = escribir_valido && escribir_listo;
    assign r = leer_valido && leer_listo;

    assign datos_salida = mem[ptr_lectura[BITS_DIRECCION-1:0]];
    assign diferencia   = ptr_escritura - ptr_lectura;

    assign actualizar = w ^ r;
    assign operacion  = w && !r;

    always_ff @(posedge clk) begin
        if (w) begin
            mem[ptr_escritura[BITS_DIRECCION-1:0]] <= datos_entrada;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_escritura   <= '0;
            ptr_lectura     <= '0;
            error_ocupacion <= 1'b0;
        end else begin
            if (w) begin
                ptr_escritura <= ptr_escritura + PASO;
            end
            if (r) begin
                ptr_lectura <= ptr_lectura + PASO;
            end
            if (ocupacion != diferencia) begin
                error_ocupacion <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_control_fifo_muestras.sv
// Directed bench for control_fifo_muestras with a behavioural occupancy counter
// alongside it; the counter output can be overridden to inject mismatches.
module tb_control_fifo_muestras;

    localparam int BITS_DATOS     = 8;
    localparam int BITS_DIRECCION = 3;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    escribir_valido;
    logic [BITS_DATOS-1:0]   datos_entrada;
    logic                    escribir_listo;
    logic                    leer_valido;
    logic [BITS_DATOS-1:0]   datos_salida;
    logic                    leer_listo;
    logic [BITS_DIRECCION:0] ocupacion;
    logic                    actualizar;
    logic                    operacion;
    logic                    error_ocupacion;

    logic [BITS_DIRECCION:0] contador;
    logic                    forzar;
    logic [BITS_DIRECCION:0] valor_forzado;

    integer checks = 0;
    integer fails  = 0;

    always #5 clk = ~clk;

    // Stand-in for the up/down occupancy counter, updated on the same edge as the pointers.
    always @(posedge clk) begin
        if (reset) begin
            contador <= '0;
        end else if (actualizar) begin
            contador <= operacion ? contador + 4'd1 : contador - 4'd1;
        end
    end

    assign ocupacion = forzar ? valor_forzado : contador;

    control_fifo_muestras #(
        .BITS_DATOS    (BITS_DATOS),
        .BITS_DIRECCION(BITS_DIRECCION)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .escribir_valido(escribir_valido),
        .datos_entrada  (datos_entrada),
        .escribir_listo (escribir_listo),
        .leer_valido    (leer_valido),
        .datos_salida   (datos_salida),
        .leer_listo     (leer_listo),
        .ocupacion      (ocupacion),
        .actualizar     (actualizar),
        .operacion      (operacion),
        .error_ocupacion(error_ocupacion)
    );

    task automatic test_reset();
        reset = 1'b1;
        escribir_valido = 1'b1;
        datos_entrada = 8'h77;
        leer_listo = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (escribir_listo !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_escribir_listo: got %b expected 0", escribir_listo);
        end
        checks++;
        if (leer_valido !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_leer_valido: got %b expected 0", leer_valido);
        end
        checks++;
        if ({actualizar, operacion} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL reset_comando: got %b%b expected 00", actualizar, operacion);
        end
        reset = 1'b0;
        escribir_valido = 1'b0;
        leer_listo = 1'b0;
        #1;
        checks++;
        if ({escribir_listo, leer_valido, error_ocupacion} !== 3'b100) begin
            fails++;
            $display("[TB] FAIL post_reset_flags: got %b expected 100",
                     {escribir_listo, leer_valido, error_ocupacion});
        end
    endtask

    task automatic test_single_write();
        @(negedge clk);
        escribir_valido = 1'b1;
        datos_entrada = 8'h11;
        #1;
        checks++;
        if ({actualizar, operacion} !== 2'b11) begin
            fails++;
            $display("[TB] FAIL write_comando: got %b%b expected 11", actualizar, operacion);
        end
        @(negedge clk);
        escribir_valido = 1'b0;
        #1;
        checks++;
        if (leer_valido !== 1'b1 || datos_salida !== 8'h11 || ocupacion !== 4'd1) begin
            fails++;
            $display("[TB] FAIL write_latency: got valido=%b datos=%h ocup=%0d expected 1 11 1",
                     leer_valido, datos_salida, ocupacion);
        end
        leer_listo = 1'b1;
        #1;
        checks++;
        if ({actualizar, operacion} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL read_comando: got %b%b expected 10", actualizar, operacion);
        end
        @(negedge clk);
        leer_listo = 1'b0;
        #1;
        checks++;
        if (leer_valido !== 1'b0) begin
            fails++;
            $display("[TB] FAIL read_empty: got %b expected 0", leer_valido);
        end
    endtask

    task automatic test_fill_and_drain();
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            escribir_valido = 1'b1;
            datos_entrada = 8'(i);
            #1;
            checks++;
            if (escribir_listo !== 1'b1) begin
                fails++;
                $display("[TB] FAIL fill_listo_%0d: got %b expected 1", i, escribir_listo);
            end
        end
        @(negedge clk);
        datos_entrada = 8'h09;
        #1;
        checks++;
        if (escribir_listo !== 1'b0 || actualizar !== 1'b0 || ocupacion !== 4'd8) begin
            fails++;
            $display("[TB] FAIL full_refuse: got listo=%b act=%b ocup=%0d expected 0 0 8",
                     escribir_listo, actualizar, ocupacion);
        end
        @(negedge clk);
        escribir_valido = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            leer_listo = 1'b1;
            #1;
            checks++;
            if (leer_valido !== 1'b1 || datos_salida !== 8'(i)) begin
                fails++;
                $display("[TB] FAIL drain_%0d: got valido=%b datos=%h expected 1 %h",
                         i, leer_valido, datos_salida, 8'(i));
            end
            @(negedge clk);
        end
        leer_listo = 1'b0;
        #1;
        checks++;
        if (leer_valido !== 1'b0 || ocupacion !== 4'd0) begin
            fails++;
            $display("[TB] FAIL drain_empty: got valido=%b ocup=%0d expected 0 0",
                     leer_valido, ocupacion);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            escribir_valido = 1'b1;
            datos_entrada = 8'h20 + 8'(i);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            escribir_valido = 1'b1;
            leer_listo = 1'b1;
            datos_entrada = 8'h24 + 8'(k);
            #1;
            checks++;
            if (actualizar !== 1'b0 || ocupacion !== 4'd4 || datos_salida !== 8'h20 + 8'(k)) begin
                fails++;
                $display("[TB] FAIL b2b_%0d: got act=%b ocup=%0d datos=%h expected 0 4 %h",
                         k, actualizar, ocupacion, datos_salida, 8'h20 + 8'(k));
            end
        end
        @(negedge clk);
        escribir_valido = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (leer_valido !== 1'b1 || datos_salida !== 8'h34 + 8'(i)) begin
                fails++;
                $display("[TB] FAIL b2b_drain_%0d: got valido=%b datos=%h expected 1 %h",
                         i, leer_valido, datos_salida, 8'h34 + 8'(i));
            end
            @(negedge clk);
        end
        leer_listo = 1'b0;
    endtask

    task automatic test_full_read_write();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            escribir_valido = 1'b1;
            datos_entrada = 8'h40 + 8'(i);
        end
        @(negedge clk);
        datos_entrada = 8'h48;
        leer_listo = 1'b1;
        #1;
        checks++;
        if (escribir_listo !== 1'b0 || {actualizar, operacion} !== 2'b10 || datos_salida !== 8'h40) begin
            fails++;
            $display("[TB] FAIL full_rw: got listo=%b cmd=%b%b datos=%h expected 0 10 40",
                     escribir_listo, actualizar, operacion, datos_salida);
        end
        @(negedge clk);
        leer_listo = 1'b0;
        #1;
        checks++;
        if (ocupacion !== 4'd7 || escribir_listo !== 1'b1 || {actualizar, operacion} !== 2'b11) begin
            fails++;
            $display("[TB] FAIL full_rw_next: got ocup=%0d listo=%b cmd=%b%b expected 7 1 11",
                     ocupacion, escribir_listo, actualizar, operacion);
        end
        @(negedge clk);
        escribir_valido = 1'b0;
        leer_listo = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            #1;
            checks++;
            if (leer_valido !== 1'b1 || datos_salida !== 8'h40 + 8'(i)) begin
                fails++;
                $display("[TB] FAIL full_drain_%0d: got valido=%b datos=%h expected 1 %h",
                         i, leer_valido, datos_salida, 8'h40 + 8'(i));
            end
            @(negedge clk);
        end
        leer_listo = 1'b0;
    endtask

    task automatic test_reset_mid_stream();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            escribir_valido = 1'b1;
            datos_entrada = 8'h60 + 8'(i);
        end
        @(negedge clk);
        escribir_valido = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (ocupacion !== 4'd0 || leer_valido !== 1'b0 || error_ocupacion !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mid_reset: got ocup=%0d valido=%b err=%b expected 0 0 0",
                     ocupacion, leer_valido, error_ocupacion);
        end
        escribir_valido = 1'b1;
        datos_entrada = 8'hAA;
        @(negedge clk);
        escribir_valido = 1'b0;
        #1;
        checks++;
        if (leer_valido !== 1'b1 || datos_salida !== 8'hAA) begin
            fails++;
            $display("[TB] FAIL mid_reset_write: got valido=%b datos=%h expected 1 aa",
                     leer_valido, datos_salida);
        end
        leer_listo = 1'b1;
        @(negedge clk);
        leer_listo = 1'b0;
    endtask

    task automatic test_error_flag();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            escribir_valido = 1'b1;
            datos_entrada = 8'h80 + 8'(i);
        end
        @(negedge clk);
        escribir_valido = 1'b0;
        forzar = 1'b1;
        valor_forzado = 4'd2;
        #1;
        checks++;
        if (error_ocupacion !== 1'b0) begin
            fails++;
            $display("[TB] FAIL error_early: got %b expected 0", error_ocupacion);
        end
        @(negedge clk);
        forzar = 1'b0;
        #1;
        checks++;
        if (error_ocupacion !== 1'b1) begin
            fails++;
            $display("[TB] FAIL error_set: got %b expected 1", error_ocupacion);
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (error_ocupacion !== 1'b1) begin
            fails++;
            $display("[TB] FAIL error_sticky: got %b expected 1", error_ocupacion);
        end
        forzar = 1'b1;
        valor_forzado = 4'd9;
        #1;
        checks++;
        if (escribir_listo !== 1'b1 || leer_valido !== 1'b1) begin
            fails++;
            $display("[TB] FAIL out_of_range: got listo=%b valido=%b expected 1 1",
                     escribir_listo, leer_valido);
        end
        forzar = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (error_ocupacion !== 1'b0 || ocupacion !== 4'd0) begin
            fails++;
            $display("[TB] FAIL error_clear: got err=%b ocup=%0d expected 0 0",
                     error_ocupacion, ocupacion);
        end
        @(negedge clk);
        #1;
        checks++;
        if (error_ocupacion !== 1'b0) begin
            fails++;
            $display("[TB] FAIL error_stays_clear: got %b expected 0", error_ocupacion);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        escribir_valido = 1'b0;
        datos_entrada = '0;
        leer_listo = 1'b0;
        forzar = 1'b0;
        valor_forzado = '0;
        test_reset();
        test_single_write();
        test_fill_and_drain();
        test_back_to_back();
        test_full_read_write();
        test_reset_mid_stream();
        test_error_flag();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
